// File: rtl/uart_tx.sv
// Serial transmitter with configurable parity and stop bits.
// Serialises one byte per accepted request, LSB first.
//   state | meaning
//   IDLE  | line high, waiting for tx_start
//   START | start bit (low)
//   DATA  | eight data bits, LSB first
//   PAR   | parity bit (only when parity is enabled)
//   STOP  | one or two stop bits (high)
module uart_tx #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 9600,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       tx_busy
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam bit PAR_EN  = (PARITY == 1) || (PARITY == 2);
  localparam bit PAR_ODD = (PARITY == 2);
  localparam logic [2:0] STOP_LAST = (STOP_BITS == 2) ? 3'd1 : 3'd0;

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       idx, idx_nxt;
  logic [7:0]       shreg, shreg_nxt;
  logic             par, par_nxt;
  logic             tx_nxt, busy_nxt;
  logic             bit_done;

  assign bit_done = (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      idx     <= '0;
      shreg   <= '0;
      par     <= 1'b0;
      tx      <= 1'b1;
      tx_busy <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      idx     <= idx_nxt;
      shreg   <= shreg_nxt;
      par     <= par_nxt;
      tx      <= tx_nxt;
      tx_busy <= busy_nxt;
    end
  end

  // tx_nxt always carries the level of the bit about to start, so tx is
  // updated on the same edge as the state and never glitches.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = bit_done ? '0 : cnt + 1'b1;
    idx_nxt   = idx;
    shreg_nxt = shreg;
    par_nxt   = par;
    tx_nxt    = tx;
    busy_nxt  = tx_busy;
    case (state)
      IDLE: begin
        cnt_nxt  = '0;
        idx_nxt  = '0;
        tx_nxt   = 1'b1;
        busy_nxt = 1'b0;
        if (tx_start) begin
          shreg_nxt = tx_data;
          par_nxt   = (^tx_data) ^ PAR_ODD;
          tx_nxt    = 1'b0;
          busy_nxt  = 1'b1;
          state_nxt = START;
        end
      end
      START: begin
        if (bit_done) begin
          idx_nxt   = '0;
          tx_nxt    = shreg[0];
          state_nxt = DATA;
        end
      end
      DATA: begin
        if (bit_done) begin
          if (idx == 3'd7) begin
            idx_nxt = '0;
            if (PAR_EN) begin
              tx_nxt    = par;
              state_nxt = PAR;
            end else begin
              tx_nxt    = 1'b1;
              state_nxt = STOP;
            end
          end else begin
            idx_nxt   = idx + 3'd1;
            shreg_nxt = {1'b0, shreg[7:1]};
            tx_nxt    = shreg[1];
          end
        end
      end
      PAR: begin
        if (bit_done) begin
          idx_nxt   = '0;
          tx_nxt    = 1'b1;
          state_nxt = STOP;
        end
      end
      STOP: begin
        tx_nxt = 1'b1;
        if (bit_done) begin
          if (idx == STOP_LAST) begin
            busy_nxt  = 1'b0;
            state_nxt = IDLE;
          end else begin
            idx_nxt = idx + 3'd1;
          end
        end
      end
      default: begin
        tx_nxt    = 1'b1;
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: five parameterisations share one clock; each frame is
// compared clock by clock against an expected bit list built from the byte.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_start;
  logic [7:0] tx_data;
  logic [2:0] sel;
  logic [4:0] start_w, tx_w, busy_w;
  logic       mon_tx, mon_busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign start_w  = tx_start ? 5'(1 << sel) : 5'b0;
  assign mon_tx   = tx_w[sel];
  assign mon_busy = busy_w[sel];

  uart_tx u_def (
    .clk(clk), .rst(rst), .tx_start(start_w[0]), .tx_data(tx_data),
    .tx(tx_w[0]), .tx_busy(busy_w[0]));
  uart_tx #(.CLK_FREQ(40), .BAUD_RATE(10), .PARITY(1), .STOP_BITS(2)) u_even2 (
    .clk(clk), .rst(rst), .tx_start(start_w[1]), .tx_data(tx_data),
    .tx(tx_w[1]), .tx_busy(busy_w[1]));
  uart_tx #(.CLK_FREQ(35), .BAUD_RATE(10), .PARITY(2), .STOP_BITS(1)) u_odd1 (
    .clk(clk), .rst(rst), .tx_start(start_w[2]), .tx_data(tx_data),
    .tx(tx_w[2]), .tx_busy(busy_w[2]));
  uart_tx #(.CLK_FREQ(59), .BAUD_RATE(10), .PARITY(0), .STOP_BITS(1)) u_none1 (
    .clk(clk), .rst(rst), .tx_start(start_w[3]), .tx_data(tx_data),
    .tx(tx_w[3]), .tx_busy(busy_w[3]));
  uart_tx #(.CLK_FREQ(7), .BAUD_RATE(7), .PARITY(3), .STOP_BITS(3)) u_fast (
    .clk(clk), .rst(rst), .tx_start(start_w[4]), .tx_data(tx_data),
    .tx(tx_w[4]), .tx_busy(busy_w[4]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // n: clocks per bit, pmode: 0 none / 1 even / 2 odd, nstop: 1 or 2.
  task automatic send_frame(input logic [7:0] d, input int n, input int pmode,
                            input int nstop, input bit hold, input int poke_bit,
                            input logic [7:0] poke_d);
    int bits[$];
    int bad;
    int ones;
    bits.push_back(0);
    for (int i = 0; i < 8; i++) bits.push_back(int'(d[i]));
    ones = $countones(d);
    if (pmode == 1) bits.push_back(ones % 2);
    else if (pmode == 2) bits.push_back(1 - (ones % 2));
    for (int s = 0; s < nstop; s++) bits.push_back(1);

    check("pre_idle", 32'(mon_busy), 32'd0);
    tx_data  = d;
    tx_start = 1'b1;
    tick();
    check("busy_rise", 32'(mon_busy), 32'd1);
    if (!hold) tx_start = 1'b0;
    tx_data = ~d;
    for (int b = 0; b < bits.size(); b++) begin
      bad = 0;
      for (int c = 0; c < n; c++) begin
        if (mon_tx !== 1'(bits[b])) bad++;
        if (mon_busy !== 1'b1) bad++;
        if (b == poke_bit && c == n / 2) begin
          tx_data  = poke_d;
          tx_start = 1'b1;
        end
        if (b == poke_bit && c == n / 2 + 1) tx_start = 1'b0;
        tick();
      end
      check($sformatf("bit%0d_of_%02h", b, d), 32'(bad), 32'd0);
    end
    check("busy_fall", 32'(mon_busy), 32'd0);
    check("stop_line", 32'(mon_tx), 32'd1);
  endtask

  task automatic idle_check(input int cyc);
    int bad;
    bad = 0;
    for (int i = 0; i < cyc; i++) begin
      if (mon_tx !== 1'b1 || mon_busy !== 1'b0) bad++;
      tick();
    end
    check("idle_quiet", 32'(bad), 32'd0);
  endtask

  task automatic rand_frames(input int count, input int n, input int pmode, input int nstop);
    bit hold;
    for (int k = 0; k < count; k++) begin
      hold = (k < count - 1) && ($urandom_range(0, 1) == 1);
      send_frame(8'($urandom), n, pmode, nstop, hold, -1, 8'h00);
    end
    tx_start = 1'b0;
    idle_check(3 * n + 2);
  endtask

  initial begin
    sel      = 3'd0;
    rst      = 1'b0;
    tx_start = 1'b1;
    tx_data  = 8'hA5;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rst_tx", 32'(tx_w), 32'h1f);
      check("rst_busy", 32'(busy_w), 32'h0);
    end
    tx_start = 1'b0;
    rst      = 1'b1;
    tick();

    // Default 5208 clocks/bit; a 0xFF request during data bit 4 must be ignored.
    sel = 3'd0;
    send_frame(8'h3C, 5208, 0, 1, 1'b0, 5, 8'hFF);
    idle_check(20);

    sel = 3'd3;
    send_frame(8'h55, 5, 0, 1, 1'b1, -1, 8'h00);
    send_frame(8'hAA, 5, 0, 1, 1'b0, -1, 8'h00);
    idle_check(12);
    rand_frames(4, 5, 0, 1);

    sel = 3'd1;
    send_frame(8'h07, 4, 1, 2, 1'b0, -1, 8'h00);
    rand_frames(6, 4, 1, 2);

    sel = 3'd2;
    send_frame(8'h07, 3, 2, 1, 1'b0, -1, 8'h00);
    rand_frames(6, 3, 2, 1);

    sel = 3'd4;
    rand_frames(6, 1, 0, 1);

    // Abort during data bit 3, then a clean frame must follow.
    sel      = 3'd2;
    tx_data  = 8'($urandom);
    tx_start = 1'b1;
    tick();
    tx_start = 1'b0;
    repeat (3 * 4 + 1) tick();
    check("rstmid_pre_busy", 32'(mon_busy), 32'd1);
    rst = 1'b0;
    tick();
    check("rstmid_tx", 32'(mon_tx), 32'd1);
    check("rstmid_busy", 32'(mon_busy), 32'd0);
    rst = 1'b1;
    tick();
    send_frame(8'($urandom), 3, 2, 1, 1'b0, -1, 8'h00);
    idle_check(5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Asynchronous serial transmitter: serialises one byte per request onto a single line in standard 8-N-1 style framing (parity and stop-bit count parameterisable).
- Sits between a byte-wide producer (CPU/FIFO) and the board-level TX pin.
- Baud timing is derived from a fixed system clock by an internal integer divider.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD_RATE, 9600, line bit rate in bits/s.
- PARITY, 0, parity mode: 0 = none, 1 = even, 2 = odd. Other values are treated as 0.
- STOP_BITS, 1, number of stop bits: 1 or 2. Other values are treated as 1.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-low reset (asserted when 0).
- tx_start  input  1  single-cycle (or longer) request to send tx_data; honoured only when idle.
- tx_data  input  8  byte to transmit; sampled in the cycle tx_start is accepted.
- tx  output  1  serial line, idle high; registered.
- tx_busy  output  1  high while a frame is in progress; registered.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-low, port rst.
- CLKS_PER_BIT = CLK_FREQ / BAUD_RATE (integer division, truncated); 5208 at the defaults. Every bit period lasts exactly CLKS_PER_BIT clocks.
- Reset (rst == 0 at a clk edge):
  - tx = 1, tx_busy = 0, state = IDLE.
  - Baud counter, bit index and shift register all cleared.
  - Reset overrides everything, including a frame in progress: the frame is aborted and the line returns high the next cycle.
- States: IDLE, START, DATA, PAR, STOP.
- IDLE:
  - tx = 1, tx_busy = 0.
  - On an edge with tx_start == 1: latch tx_data into the shift register; tx <= 0 and tx_busy <= 1 at that same edge; baud counter cleared; go to START.
  - tx_data changes after acceptance do not affect the current frame.
- START: tx = 0 for CLKS_PER_BIT clocks, then go to DATA with bit index 0.
- DATA:
  - Bits sent LSB first (bit 0 first), each for CLKS_PER_BIT clocks.
  - After bit 7: go to PAR if PARITY != 0, else go to STOP.
- PAR:
  - Even parity: tx = XOR of the 8 data bits. Odd parity: its inverse.
  - Lasts one bit period, then go to STOP.
- STOP:
  - tx = 1 for STOP_BITS × CLKS_PER_BIT clocks.
  - At the final clock: state <= IDLE and tx_busy <= 0.
- Frame length: total tx_busy high time = (1 + 8 + P + STOP_BITS) × CLKS_PER_BIT clocks, where P = 1 if parity is enabled, else 0. At the defaults this is 52080 clocks.
- tx_start is ignored whenever tx_busy = 1 (no queueing).
- A tx_start held high continuously across a frame end starts the next frame on the first IDLE cycle. Back-to-back frames therefore have exactly one idle-high clock between the last stop bit and the next start bit.
- tx has no glitches: driven only from registers.
- The baud counter width must hold CLKS_PER_BIT − 1.
- CLKS_PER_BIT < 1 is a configuration error and is not supported.

Test Plan:
- Reset: hold rst = 0 for 5 clocks with tx_start = 1 → tx = 1 and tx_busy = 0 throughout; no frame starts.
- Default frame: release reset, pulse tx_start for 1 clock with tx_data = 0x3C →
  - tx_busy rises at the accepting edge.
  - Line sequence, each bit 5208 clocks: 0 | 0,0,1,1,1,1,0,0 | 1.
  - tx_busy falls exactly 52080 clocks after rising; tx = 1 afterwards.
- Ignore while busy: during the 0x3C frame, pulse tx_start with tx_data = 0xFF at bit 4 → frame is unchanged; no second frame follows.
- Back-to-back: hold tx_start = 1 with 0x55 then 0xAA →
  - Two frames; data bits 1,0,1,0,1,0,1,0 then 0,1,0,1,0,1,0,1.
  - Exactly one idle clock between the frames.
- Parity and stop bits: PARITY = 1 and STOP_BITS = 2 with BAUD_RATE chosen so CLKS_PER_BIT = 4; send 0x07 →
  - Parity bit = 1.
  - Stop high for 8 clocks.
  - tx_busy high for 48 clocks.
  - With PARITY = 2 the parity bit = 0.
- Reset mid-frame: assert rst = 0 during data bit 3 → next edge gives tx = 1 and tx_busy = 0. After release, a new tx_start sends a complete, correct frame.
